// File: rtl/cpc_sixrom_pkg.sv
// rtl/cpc_sixrom_pkg.sv - shared types, constants and decode helper for the six-ROM bank controller
package cpc_sixrom_pkg;

  typedef enum logic [1:0] {IDLE, QUAL, CAPT, HOLD} wr_state_t;

  localparam int NUM_SLOTS   = 6;
  localparam int BASE_LSB    = 0;
  localparam int BASE_MSB    = 3;
  localparam int SOCK_EN_LSB = 4;
  localparam int SOCK_EN_MSB = 6;
  localparam int LOWER_EN    = 7;

  // Bit 0 = socket 01, bit 1 = socket 23, bit 2 = socket 45.
  function automatic logic [2:0] sock_onehot(input logic [1:0] sock);
    case (sock)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/io_wr_detect.sv
// rtl/io_wr_detect.sv - deglitched, edge-qualified capture of writes to the upper-ROM select port
module io_wr_detect
  import cpc_sixrom_pkg::*;
#(
  parameter int DEGLITCH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qual,
  input  logic       wr_end,
  input  logic [7:0] d,
  output logic       cap_stb,
  output logic [7:0] rom_sel
);

  localparam logic [2:0] DG = 3'(DEGLITCH);

  wr_state_t  state, state_nxt;
  logic [1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_sel <= 8'h00;
    end else if (state == CAPT) begin
      rom_sel <= d;
    end
  end

  // HOLD waits for the strobes to release so one I/O cycle yields one capture.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (qual) begin
          cnt_nxt   = 2'd1;
          state_nxt = (DG <= 3'd1) ? CAPT : QUAL;
        end
      end
      QUAL: begin
        if (!qual) begin
          state_nxt = IDLE;
        end else if (({1'b0, cnt} + 3'd1) >= DG) begin
          state_nxt = CAPT;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      CAPT: state_nxt = HOLD;
      HOLD: begin
        if (wr_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cap_stb = (state == CAPT);

endmodule

// File: rtl/rom_bank_ctrl.sv
// rtl/rom_bank_ctrl.sv - six-ROM bank select: window compare and chip-select gating
// Optional lower-ROM replacement via socket 01 image 0 when LOWER_ROM_EN is defined.
module rom_bank_ctrl
  import cpc_sixrom_pkg::*;
#(
  parameter int DEGLITCH = 2
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       A15,
  input  logic       A14,
  input  logic       A13,
  input  logic [7:0] D,
  input  logic       IOREQ_B,
  input  logic       WR_B,
  input  logic       RD_B,
  input  logic       MREQ_B,
  input  logic       ROMEN_B,
  input  logic [7:0] dip,
  output logic       rom01cs_b,
  output logic       rom23cs_b,
  output logic       rom45cs_b,
  output logic       romoe_b,
  output logic       roma14,
  output logic       romdis_pre
);

  logic       qual;
  logic       wr_end;
  logic       cap_stb;
  logic [7:0] rom_sel;
  logic [3:0] base_q;
  logic [2:0] sock_en_q;
  logic [7:0] slot;
  logic       valid;
  logic [2:0] sel_cs;
  logic       hit;
  logic       upper;
  logic       lower;
  logic [2:0] cs_act;

  assign qual   = ~IOREQ_B & ~WR_B & ~A13;
  assign wr_end = IOREQ_B | WR_B;

  io_wr_detect #(
    .DEGLITCH(DEGLITCH)
  ) u_wr_detect (
    .clk    (CLK),
    .rst_n  (RESET_B),
    .qual   (qual),
    .wr_end (wr_end),
    .d      (D),
    .cap_stb(cap_stb),
    .rom_sel(rom_sel)
  );

  // DIP window is snapshotted alongside rom_sel so switch changes wait for the next capture.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      base_q    <= 4'd0;
      sock_en_q <= 3'd0;
    end else if (cap_stb) begin
      base_q    <= dip[BASE_MSB:BASE_LSB];
      sock_en_q <= dip[SOCK_EN_MSB:SOCK_EN_LSB];
    end
  end

  assign slot   = rom_sel - {4'b0000, base_q};
  assign valid  = (rom_sel >= {4'b0000, base_q}) && (slot < 8'(NUM_SLOTS));
  assign sel_cs = sock_onehot(slot[2:1]);
  assign hit    = valid & |(sel_cs & sock_en_q);

  assign upper = ~ROMEN_B & A15 & A14 & hit;

`ifdef LOWER_ROM_EN
  assign lower = dip[LOWER_EN] & ~MREQ_B & ~ROMEN_B & ~A15 & ~A14;
`else
  logic unused_lower;
  assign lower        = 1'b0;
  assign unused_lower = ^{MREQ_B, dip[LOWER_EN]};
`endif

  assign cs_act = lower ? 3'b001 : (upper ? sel_cs : 3'b000);

  assign rom01cs_b  = ~cs_act[0];
  assign rom23cs_b  = ~cs_act[1];
  assign rom45cs_b  = ~cs_act[2];
  assign romoe_b    = ~((upper | lower) & ~RD_B);
  assign roma14     = lower ? 1'b0 : slot[0];
  // Held across the whole upper window, not just reads, so the internal ROM never contends.
  assign romdis_pre = (hit & A15 & A14) | lower;

endmodule

// File: tb/tb_rom_bank_ctrl.sv
// tb/tb_rom_bank_ctrl.sv - self-checking bench for rom_bank_ctrl with a behavioural selection model
module tb_rom_bank_ctrl;

  localparam int DEGLITCH = 2;

  logic       CLK = 1'b0;
  logic       RESET_B;
  logic       A15, A14, A13;
  logic [7:0] D;
  logic       IOREQ_B, WR_B, RD_B, MREQ_B, ROMEN_B;
  logic [7:0] dip;
  logic       rom01cs_b, rom23cs_b, rom45cs_b, romoe_b, roma14, romdis_pre;

  int checks = 0;
  int errors = 0;

  rom_bank_ctrl #(
    .DEGLITCH(DEGLITCH)
  ) dut (
    .CLK       (CLK),
    .RESET_B   (RESET_B),
    .A15       (A15),
    .A14       (A14),
    .A13       (A13),
    .D         (D),
    .IOREQ_B   (IOREQ_B),
    .WR_B      (WR_B),
    .RD_B      (RD_B),
    .MREQ_B    (MREQ_B),
    .ROMEN_B   (ROMEN_B),
    .dip       (dip),
    .rom01cs_b (rom01cs_b),
    .rom23cs_b (rom23cs_b),
    .rom45cs_b (rom45cs_b),
    .romoe_b   (romoe_b),
    .roma14    (roma14),
    .romdis_pre(romdis_pre)
  );

  always #5 CLK = ~CLK;

  // Model: selected ROM number, DIP snapshot, and a run-length view of write qualification.
  logic [7:0] m_sel  = 8'h00;
  logic [3:0] m_base = 4'h0;
  logic [2:0] m_en   = 3'b000;
  int         m_run  = 0;
  bit         m_pend = 1'b0;
  bit         m_hold = 1'b0;
  int         m_caps = 0;

  always @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      m_sel  <= 8'h00;
      m_base <= 4'h0;
      m_en   <= 3'b000;
      m_run  <= 0;
      m_pend <= 1'b0;
      m_hold <= 1'b0;
    end else if (m_pend) begin
      m_sel  <= D;
      m_base <= dip[3:0];
      m_en   <= dip[6:4];
      m_pend <= 1'b0;
      m_hold <= 1'b1;
      m_caps <= m_caps + 1;
    end else if (m_hold) begin
      if (IOREQ_B || WR_B) m_hold <= 1'b0;
    end else if (!IOREQ_B && !WR_B && !A13) begin
      if (m_run + 1 >= DEGLITCH) begin
        m_pend <= 1'b1;
        m_run  <= 0;
      end else begin
        m_run <= m_run + 1;
      end
    end else begin
      m_run <= 0;
    end
  end

  // Output order: {rom01cs_b, rom23cs_b, rom45cs_b, romoe_b, roma14, romdis_pre}
  function automatic logic [5:0] model_out();
    int         s;
    bit         h;
    bit         up;
    bit         lo;
    logic [2:0] cs;
    logic       a14;
    s   = int'(m_sel) - int'(m_base);
    h   = 1'b0;
    cs  = 3'b111;
    a14 = s[0];
    if (s >= 0 && s < 6) h = m_en[s / 2];
    up = !ROMEN_B && A15 && A14 && h;
    if (up) cs[2 - s / 2] = 1'b0;
    lo = 1'b0;
`ifdef LOWER_ROM_EN
    lo = dip[7] && !MREQ_B && !ROMEN_B && !A15 && !A14;
    if (lo) begin
      cs  = 3'b011;
      a14 = 1'b0;
    end
`endif
    return {cs, !((up || lo) && !RD_B), a14, (h && A15 && A14) || lo};
  endfunction

  function automatic logic [5:0] dut_out();
    return {rom01cs_b, rom23cs_b, rom45cs_b, romoe_b, roma14, romdis_pre};
  endfunction

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    chk("cycle_model", dut_out(), model_out());
    @(posedge CLK);
    #2;
  endtask

  task automatic bus_idle();
    IOREQ_B = 1'b1; WR_B = 1'b1; RD_B = 1'b1; MREQ_B = 1'b1; ROMEN_B = 1'b1;
    A15 = 1'b0; A14 = 1'b0; A13 = 1'b0;
  endtask

  task automatic io_out(input logic [7:0] data, input int n);
    bus_idle();
    A15 = 1'b1; A14 = 1'b1; A13 = 1'b0; D = data;
    IOREQ_B = 1'b0; WR_B = 1'b0;
    repeat (n) step();
    IOREQ_B = 1'b1; WR_B = 1'b1;
    step();
    step();
  endtask

  task automatic read_chk(input string name, input logic a15, input logic a14, input logic [5:0] exp);
    IOREQ_B = 1'b1; WR_B = 1'b1;
    A15 = a15; A14 = a14; A13 = 1'b0;
    MREQ_B = 1'b0; ROMEN_B = 1'b0; RD_B = 1'b0;
    #1 chk(name, dut_out(), exp);
    step();
    bus_idle();
  endtask

  int caps0;

  initial begin
    bus_idle();
    D = 8'h00; dip = 8'h77; RESET_B = 1'b0;
    repeat (3) step();
    #1 chk("reset_out", dut_out(), 6'b111100);
    RESET_B = 1'b1;
    step();

    // Capture latency: hit appears at the second edge after the first qualified edge.
    A15 = 1'b1; A14 = 1'b1; A13 = 1'b0; D = 8'd9;
    IOREQ_B = 1'b0; WR_B = 1'b0;
    step();
    step();
    #1 chk_int("romdis_before_capt", int'(romdis_pre), 0);
    step();
    #1 chk_int("romdis_at_capt", int'(romdis_pre), 1);
    IOREQ_B = 1'b1; WR_B = 1'b1;
    step();
    step();
    chk_int("model_sel_9", int'(m_sel), 9);
    read_chk("hit_rom9", 1'b1, 1'b1, 6'b101001);

    io_out(8'd13, 3);
    read_chk("miss_rom13", 1'b1, 1'b1, 6'b111100);
    io_out(8'd6, 3);
    read_chk("miss_rom6", 1'b1, 1'b1, 6'b111110);

    io_out(8'd9, 3);
    caps0 = m_caps;
    io_out(8'd8, 1);
    chk_int("glitch_caps", m_caps - caps0, 0);
    read_chk("glitch_keeps_rom9", 1'b1, 1'b1, 6'b101001);

    // Long write: data changes mid-hold; a second capture would latch 8 instead of 12.
    caps0 = m_caps;
    bus_idle();
    A15 = 1'b1; A14 = 1'b1; A13 = 1'b0; D = 8'd12;
    IOREQ_B = 1'b0; WR_B = 1'b0;
    repeat (3) step();
    D = 8'd8;
    repeat (7) step();
    IOREQ_B = 1'b1; WR_B = 1'b1;
    step();
    step();
    chk_int("long_write_caps", m_caps - caps0, 1);
    read_chk("long_write_rom12", 1'b1, 1'b1, 6'b110011);

    dip = 8'h07;
    read_chk("dip_not_live", 1'b1, 1'b1, 6'b110011);

    dip = 8'h57;
    io_out(8'd9, 3);
    read_chk("sock23_off_rom9", 1'b1, 1'b1, 6'b111100);
    io_out(8'd12, 3);
    read_chk("sock45_rom12", 1'b1, 1'b1, 6'b110011);

    dip = 8'hD7;
`ifdef LOWER_ROM_EN
    read_chk("lower_read", 1'b0, 1'b0, 6'b011001);
`else
    read_chk("lower_absent", 1'b0, 1'b0, 6'b111110);
`endif
    read_chk("upper_with_dip7", 1'b1, 1'b1, 6'b110011);

    // Asynchronous reset while a write is in QUAL and an upper read is live.
    dip = 8'h57;
    bus_idle();
    A15 = 1'b1; A14 = 1'b1; A13 = 1'b0; D = 8'd9;
    IOREQ_B = 1'b0; WR_B = 1'b0; ROMEN_B = 1'b0; RD_B = 1'b0;
    #1 chk("pre_reset_out", dut_out(), 6'b110011);
    step();
    #1 RESET_B = 1'b0;
    #1 chk("async_reset_out", dut_out(), 6'b111100);
    bus_idle();
    step();
    RESET_B = 1'b1;
    step();
    read_chk("post_reset_read", 1'b1, 1'b1, 6'b111100);

    dip = 8'h77;
    io_out(8'd9, 3);
    read_chk("requalified_rom9", 1'b1, 1'b1, 6'b101001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
